// File: rtl/pcs_receive_if.sv
// Code-group input bundle from the 8b/10b decoder and sync block, plus the
// rebuilt GMII receive outputs. One code-group is presented per GTX_CLK edge.
interface pcs_receive_if;
  logic [7:0] rx_data;
  logic       rx_is_k;
  logic       rx_cg_err;
  logic       rx_even;
  logic       sync_status;
  logic [7:0] RXD;
  logic       RX_DV;
  logic       RX_ER;
  logic       receiving;
  logic [3:0] rx_state;

  // Handshake: none. A new code-group is valid on every rising edge and the
  // receiver always accepts it; outputs are registered one edge later.
  modport master (
    output rx_data, rx_is_k, rx_cg_err, rx_even, sync_status,
    input  RXD, RX_DV, RX_ER, receiving, rx_state
  );

  modport slave (
    input  rx_data, rx_is_k, rx_cg_err, rx_even, sync_status,
    output RXD, RX_DV, RX_ER, receiving, rx_state
  );
endinterface

// File: rtl/pcs_receive.sv
// 1000BASE-X PCS receive FSM: decoded code-groups in, GMII RXD/RX_DV/RX_ER out.
// Optional statistics counters frame_cnt/err_cnt are built when PCS_RX_STATS_EN is defined.
module pcs_receive #(
  parameter logic [7:0] PREAMBLE_BYTE = 8'h55
`ifdef PCS_RX_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input logic          GTX_CLK,
  input logic          mr_main_reset,
  pcs_receive_if.slave rx_if
`ifdef PCS_RX_STATS_EN
  , output logic [CNT_W-1:0] frame_cnt
  , output logic [CNT_W-1:0] err_cnt
`endif
);

  typedef enum logic [3:0] {
    LINK_FAILED     = 4'd0,
    WAIT_FOR_K      = 4'd1,
    RX_K            = 4'd2,
    RX_CB           = 4'd3,
    IDLE_D          = 4'd4,
    START_OF_PACKET = 4'd5,
    RECEIVE         = 4'd6,
    TRI             = 4'd7,
    EXTEND          = 4'd8,
    FALSE_CARRIER   = 4'd9
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_rxd, w_rxd_nxt;
  logic       r_dv, w_dv_nxt;
  logic       r_er, w_er_nxt;
  logic       r_rcv, w_rcv_nxt;
  logic       w_tri_entry;

  logic w_ok, w_k, w_d, w_k28_5, w_comma, w_s, w_t, w_r, w_idle_oct, w_cfg_oct;

  // Every symbol match requires a clean code-group; errored ones never decode.
  assign w_ok       = !rx_if.rx_cg_err;
  assign w_k        = w_ok && rx_if.rx_is_k;
  assign w_d        = w_ok && !rx_if.rx_is_k;
  assign w_k28_5    = w_k && (rx_if.rx_data == 8'hBC);
  assign w_comma    = w_k28_5 && rx_if.rx_even;
  assign w_s        = w_k && (rx_if.rx_data == 8'hFB);
  assign w_t        = w_k && (rx_if.rx_data == 8'hFD);
  assign w_r        = w_k && (rx_if.rx_data == 8'hF7);
  assign w_idle_oct = w_d && ((rx_if.rx_data == 8'h50) || (rx_if.rx_data == 8'hC5));
  assign w_cfg_oct  = w_d && ((rx_if.rx_data == 8'hB5) || (rx_if.rx_data == 8'h42));

  always_comb begin
    w_state_nxt = r_state;
    w_rxd_nxt   = 8'h00;
    w_dv_nxt    = 1'b0;
    w_er_nxt    = 1'b0;
    w_tri_entry = 1'b0;
    if (!rx_if.sync_status) begin
      w_state_nxt = LINK_FAILED;
      w_er_nxt    = r_rcv;
    end else begin
      case (r_state)
        LINK_FAILED: w_state_nxt = WAIT_FOR_K;
        WAIT_FOR_K:  if (w_comma) w_state_nxt = RX_K;
        RX_K: begin
          if (w_cfg_oct)       w_state_nxt = RX_CB;
          else if (w_idle_oct) w_state_nxt = IDLE_D;
          else                 w_state_nxt = WAIT_FOR_K;
        end
        RX_CB: w_state_nxt = w_comma ? RX_K : WAIT_FOR_K;
        IDLE_D: begin
          if (!w_ok) begin
            w_state_nxt = WAIT_FOR_K;
          end else if (w_comma) begin
            w_state_nxt = RX_K;
          end else if (w_s) begin
            w_state_nxt = START_OF_PACKET;
            w_rxd_nxt   = PREAMBLE_BYTE;
            w_dv_nxt    = 1'b1;
          end else begin
            w_state_nxt = FALSE_CARRIER;
            w_er_nxt    = 1'b1;
            w_rxd_nxt   = 8'h0E;
          end
        end
        // The code-group following /S/ is already frame data.
        START_OF_PACKET, RECEIVE: begin
          if (w_t) begin
            w_state_nxt = TRI;
            w_tri_entry = 1'b1;
          end else if (w_k28_5) begin
            w_state_nxt = RX_K;
            w_dv_nxt    = 1'b1;
            w_er_nxt    = 1'b1;
            w_rxd_nxt   = rx_if.rx_data;
          end else begin
            w_state_nxt = RECEIVE;
            w_dv_nxt    = 1'b1;
            w_er_nxt    = !w_d;
            w_rxd_nxt   = rx_if.rx_data;
          end
        end
        // The first /R/ belongs to the end delimiter; only later ones extend carrier.
        TRI: begin
          if (w_r) begin
            w_state_nxt = EXTEND;
          end else begin
            w_state_nxt = WAIT_FOR_K;
            w_er_nxt    = 1'b1;
          end
        end
        EXTEND: begin
          if (w_r) begin
            w_er_nxt  = 1'b1;
            w_rxd_nxt = 8'h0F;
          end else if (w_comma) begin
            w_state_nxt = RX_K;
          end else begin
            w_state_nxt = WAIT_FOR_K;
            w_er_nxt    = 1'b1;
            w_rxd_nxt   = 8'h0F;
          end
        end
        FALSE_CARRIER: begin
          if (w_comma) begin
            w_state_nxt = RX_K;
          end else begin
            w_er_nxt  = 1'b1;
            w_rxd_nxt = 8'h0E;
          end
        end
        default: w_state_nxt = LINK_FAILED;
      endcase
    end
  end

  always_comb begin
    w_rcv_nxt = 1'b0;
    case (w_state_nxt)
      START_OF_PACKET, RECEIVE, TRI, EXTEND, FALSE_CARRIER: w_rcv_nxt = 1'b1;
      default:                                              w_rcv_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge GTX_CLK) begin
    if (!mr_main_reset) begin
      r_state <= LINK_FAILED;
      r_rxd   <= 8'h00;
      r_dv    <= 1'b0;
      r_er    <= 1'b0;
      r_rcv   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rxd   <= w_rxd_nxt;
      r_dv    <= w_dv_nxt;
      r_er    <= w_er_nxt;
      r_rcv   <= w_rcv_nxt;
    end
  end

  assign rx_if.RXD       = r_rxd;
  assign rx_if.RX_DV     = r_dv;
  assign rx_if.RX_ER     = r_er;
  assign rx_if.receiving = r_rcv;
  assign rx_if.rx_state  = r_state;

`ifdef PCS_RX_STATS_EN
  logic [CNT_W-1:0] r_frame_cnt, r_err_cnt;

  // Counters update on the same edge that registers the event they count.
  always_ff @(posedge GTX_CLK) begin
    if (!mr_main_reset) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_tri_entry && (r_frame_cnt != '1)) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (w_er_nxt && w_rcv_nxt && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
`else
  logic w_unused_tri;
  assign w_unused_tri = w_tri_entry;
`endif

endmodule

// File: doc/pcs_receive.md
Name: pcs_receive

Overview:
- 1000BASE-X PCS receive state machine: far end of the transmit path driven by TXD/TX_EN/TX_ER.
- Consumes one decoded code-group per GTX_CLK from the 8b/10b decoder and the synchronisation block (sync_status, rx_even).
- Rebuilds GMII receive signals RXD/RX_DV/RX_ER and the carrier indication `receiving`.
- Delimiter handling: /S/ /T/ /R/ /V/, idle and config ordered sets, false carrier, early end, loss of sync.

Parameters:
- PREAMBLE_BYTE, 8'h55, RXD value driven in the start-of-packet cycle (replaces /S/).
- CNT_W, 16, width of optional statistics counters.

Ports:
- GTX_CLK  input  1  sole clock, one code-group per rising edge.
- mr_main_reset  input  1  synchronous, active-low reset.
- rx_data  input  8  decoded octet of current code-group.
- rx_is_k  input  1  1 = special (K) code-group.
- rx_cg_err  input  1  1 = invalid code-group or running-disparity error.
- rx_even  input  1  1 = current code-group is in an even slot.
- sync_status  input  1  1 = synchronisation acquired.
- RXD  output  8  GMII receive data.
- RX_DV  output  1  GMII receive data valid.
- RX_ER  output  1  GMII receive error.
- receiving  output  1  carrier/in-frame indication.
- rx_state  output  4  current FSM state encoding, debug only.

Behaviour:
- Synchronous active-low reset (mr_main_reset=0 at a rising edge of GTX_CLK):
  - state = LINK_FAILED.
  - RXD = 8'h00, RX_DV = 0, RX_ER = 0, receiving = 0.
- All outputs registered. Latency: response to code-group sampled at edge N appears after edge N. No backpressure; input valid every cycle.
- Code-group symbols:
  - K28.5 = K 0xBC; /S/ = K 0xFB; /T/ = K 0xFD; /R/ = K 0xF7; /V/ = K 0xFE.
  - Idle second octet: D16.2 = 0x50 or D5.6 = 0xC5.
  - Config second octet: D21.5 = 0xB5 or D2.2 = 0x42.
  - "COMMA" means K28.5 with rx_even = 1.
- Outputs by state (unless a transition rule overrides):
  - Default: RX_DV = 0, RX_ER = 0, RXD = 0x00.
  - RECEIVE: RX_DV = 1, RXD = rx_data.
  - FALSE_CARRIER: RX_ER = 1, RXD = 0x0E.
  - EXTEND: RX_ER = 1, RXD = 0x0F.
  - receiving = 1 in START_OF_PACKET, RECEIVE, TRI, EXTEND, FALSE_CARRIER; 0 otherwise.
- State transitions. sync_status = 0 has priority over every rule below.
  - LINK_FAILED:
    - sync_status = 1 -> WAIT_FOR_K.
  - WAIT_FOR_K:
    - COMMA -> RX_K.
    - Else stay.
  - RX_K (code-group after a COMMA):
    - Config octet, not K -> RX_CB.
    - Idle octet, not K -> IDLE_D.
    - Anything else -> WAIT_FOR_K, with RX_ER = 0.
  - RX_CB:
    - COMMA -> RX_K.
    - Other -> WAIT_FOR_K.
  - IDLE_D:
    - COMMA -> RX_K.
    - /S/ -> START_OF_PACKET; that cycle RXD = PREAMBLE_BYTE, RX_DV = 1.
    - Any other code-group -> FALSE_CARRIER.
  - START_OF_PACKET:
    - Unconditionally -> RECEIVE; the current code-group is processed under RECEIVE rules.
  - RECEIVE:
    - D code-group without error -> stay, RXD = rx_data.
    - /V/ or rx_cg_err = 1 -> stay, RX_DV = 1, RX_ER = 1 (data error).
    - /T/ -> TRI; that cycle RX_DV = 0, RX_ER = 0.
    - K28.5 (either slot) -> early end: RX_DV = 1, RX_ER = 1 for one cycle, then RX_K.
    - Any other K -> treated as data error.
  - TRI:
    - /R/ -> EXTEND check. If rx_even = 1 next, expect COMMA.
    - Non-/R/ -> one cycle RX_ER = 1, then WAIT_FOR_K.
  - EXTEND:
    - /R/ -> stay (carrier extension).
    - COMMA -> RX_K with RX_ER = 0.
    - Other -> RX_ER = 1, then WAIT_FOR_K.
  - FALSE_CARRIER:
    - COMMA -> RX_K.
    - Else stay.
- Loss of sync in any state -> LINK_FAILED on the next edge. If receiving was 1, that edge drives RX_ER = 1, RX_DV = 0 for one cycle; otherwise outputs go quiet.
- Reset asserted mid-frame: immediate return to reset values; no error cycle is emitted.
- rx_cg_err outside RECEIVE -> WAIT_FOR_K. In FALSE_CARRIER it has no additional effect.

Optional Feature:
- Macro PCS_RX_STATS_EN.
- Defined: adds outputs frame_cnt[CNT_W-1:0] and err_cnt[CNT_W-1:0], both reset to 0 and saturating at all-ones.
  - frame_cnt increments on each TRI entry from RECEIVE.
  - err_cnt increments on every cycle with RX_ER = 1 while receiving = 1.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset, then sync_status = 1 and repeating /K28.5 (even) D16.2/ -> state cycles RX_K/IDLE_D; RX_DV = 0, RX_ER = 0, receiving = 0.
- Idle, /S/, D 0x55×6, 0xD5, 0x01, 0x02, /T/ /R/, COMMA -> RXD sequence 55,55…,D5,01,02 with RX_DV = 1, each one cycle after input; RX_DV drops the cycle /T/ is seen; receiving falls on the RX_K cycle; frame_cnt = 1 if enabled.
- Frame with /V/ replacing byte 0x01 -> that cycle RX_DV = 1, RX_ER = 1, RXD = 0xFE; neighbours clean; err_cnt = 1.
- Idle, then D 0x33 in place of K28.5 -> RX_ER = 1, RXD = 0x0E until next COMMA, then RX_K; RX_DV stays 0.
- Mid-frame sync_status = 0 -> next cycle RX_ER = 1, RX_DV = 0, then LINK_FAILED with all outputs 0. Repeat with mr_main_reset = 0 mid-frame -> outputs 0 next cycle, no error pulse.
- Frame ending /T/ /R/ /R/ /R/ COMMA -> RX_ER = 1, RXD = 0x0F on the extension cycles, RX_DV = 0; then clean idle.
